// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with iterative shifts and valid/ready handshakes.
// Define ALU_SEQ_MUL_EN to add the shift-add multiplier on opcode 1100.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_f,
   output logic             zero_f,
   output logic             over_f,
   output logic             cout_f,
   output logic             illegal_f
);
   localparam int SHW = $clog2(WIDTH);
   localparam int M = WIDTH - 1;
   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0011;
   localparam logic [3:0] OP_OR   = 4'b0100;
   localparam logic [3:0] OP_XOR  = 4'b0101;
   localparam logic [3:0] OP_SLT  = 4'b0110;
   localparam logic [3:0] OP_EQ   = 4'b0111;
   localparam logic [3:0] OP_SLTU = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b1001;
   localparam logic [3:0] OP_SRL  = 4'b1010;
   localparam logic [3:0] OP_SRA  = 4'b1011;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t           state;
   logic [3:0]       op_r;
   logic [WIDTH-1:0] wk, wk_n, res, bres, xb;
   logic [SHW:0]     cnt;
   logic [WIDTH:0]   sum;
   logic             sub, ovf, c, o, ill, is_sh, is_mul, multi, accept, bovf;
   assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
   assign out_valid = state == DONE;
   assign accept    = in_valid && in_ready;
   assign is_sh     = alu_op inside {OP_SLL, OP_SRL, OP_SRA};
   assign multi     = (is_sh && b[SHW-1:0] != '0) || is_mul;
   assign wk_n      = op_r == OP_SLL ? wk << 1 : op_r == OP_SRL ? wk >> 1 : {wk[M], wk[M:1]};
   // compare ops share the subtractor, so their carry/overflow flags come from a-b
   always_comb begin
      sub = alu_op != OP_ADD;
      xb  = sub ? ~b : b;
      sum = {1'b0, a} + {1'b0, xb} + {{WIDTH{1'b0}}, sub};
      ovf = (a[M] == xb[M]) && (sum[M] != a[M]);
      res = '0;
      c   = 1'b0;
      o   = 1'b0;
      ill = 1'b0;
      case (alu_op)
         OP_ADD, OP_SUB: begin res = sum[M:0]; c = sum[WIDTH]; o = ovf; end
         OP_AND: res = a & b;
         OP_OR:  res = a | b;
         OP_XOR: res = a ^ b;
         OP_SLT:  begin res = {{M{1'b0}}, sum[M] ^ ovf}; c = sum[WIDTH]; o = ovf; end
         OP_EQ:   begin res = {{M{1'b0}}, a == b};       c = sum[WIDTH]; o = ovf; end
         OP_SLTU: begin res = {{M{1'b0}}, ~sum[WIDTH]};  c = sum[WIDTH]; o = ovf; end
         OP_SLL, OP_SRL, OP_SRA: res = a;
         default: ill = 1'b1;
      endcase
   end
`ifdef ALU_SEQ_MUL_EN
   localparam logic [3:0] OP_MUL = 4'b1100;
   logic [2*WIDTH-1:0] acc, acc_n;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH:0]     psum;
   assign is_mul = alu_op == OP_MUL;
   // multiplier sits in the low half of acc and is consumed LSB-first
   assign psum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? mcand : {WIDTH{1'b0}}};
   assign acc_n  = {psum, acc[M:1]};
   assign bres   = op_r == OP_MUL ? acc_n[M:0] : wk_n;
   assign bovf   = op_r == OP_MUL && |acc_n[2*WIDTH-1:WIDTH];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         mcand <= '0;
      end else if (accept) begin
         acc   <= {{WIDTH{1'b0}}, b};
         mcand <= a;
      end else if (state == BUSY) acc <= acc_n;
   end
`else
   assign is_mul = 1'b0;
   assign bres   = wk_n;
   assign bovf   = 1'b0;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         op_r      <= '0;
         wk        <= '0;
         cnt       <= '0;
         alu_f     <= '0;
         zero_f    <= 1'b0;
         over_f    <= 1'b0;
         cout_f    <= 1'b0;
         illegal_f <= 1'b0;
      end else if (state == BUSY) begin
         wk  <= wk_n;
         cnt <= cnt - 1'b1;
         if (cnt == {{SHW{1'b0}}, 1'b1}) begin
            state     <= DONE;
            alu_f     <= bres;
            zero_f    <= (bres == '0);
            over_f    <= bovf;
            cout_f    <= 1'b0;
            illegal_f <= 1'b0;
         end
      end else if (accept) begin
         op_r <= alu_op;
         wk   <= a;
         cnt  <= is_mul ? (SHW+1)'(WIDTH) : {1'b0, b[SHW-1:0]};
         if (multi) state <= BUSY;
         else begin
            state     <= DONE;
            alu_f     <= res;
            zero_f    <= (res == '0);
            over_f    <= o;
            cout_f    <= c;
            illegal_f <= ill;
         end
      end else if (out_ready) state <= IDLE;
   end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=8), follows ALU_SEQ_MUL_EN like the design.
module tb_alu_seq;
   logic       clk = 0, rst = 1, in_valid = 0, out_ready = 1;
   logic       in_ready, out_valid, zero_f, over_f, cout_f, illegal_f;
   logic [3:0] alu_op = 0;
   logic [7:0] a = 0, b = 0, alu_f;
   int         errors = 0, checks = 0, cyc = 0, acc_cyc = 0;
   typedef struct packed {logic [7:0] r; logic z, o, c, i;} exp_t;
   typedef struct packed {logic [3:0] op; logic [7:0] x; logic [7:0] y;} vec_t;
   exp_t sb[$];
   vec_t vecs [0:17] = '{
      {4'h0, 8'hFF, 8'h01}, {4'h1, 8'h00, 8'h01}, {4'h1, 8'h80, 8'h01}, {4'h3, 8'hF0, 8'h3C},
      {4'h4, 8'hF0, 8'h0C}, {4'h5, 8'hFF, 8'hFF}, {4'h6, 8'h80, 8'h01}, {4'h6, 8'h01, 8'h80},
      {4'h7, 8'h5A, 8'h5A}, {4'h7, 8'h5A, 8'h5B}, {4'h8, 8'hFF, 8'h01}, {4'h9, 8'h81, 8'h09},
      {4'hA, 8'h80, 8'h07}, {4'hB, 8'h90, 8'h00}, {4'h2, 8'h12, 8'h34}, {4'hF, 8'h12, 8'h34},
      {4'hC, 8'hFF, 8'hFF}, {4'hC, 8'h03, 8'h05}};

   alu_seq #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .alu_f(alu_f),
      .zero_f(zero_f), .over_f(over_f), .cout_f(cout_f), .illegal_f(illegal_f));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
      exp_t e = '0;
      int sx = $signed(x), sy = $signed(y);
      int sd = sx - sy, ss = sx + sy;
      logic [2:0] sh = y[2:0];
      logic [15:0] p = 16'(x) * 16'(y);
      logic subov = sd > 127 || sd < -128;
      logic ge = x >= y;
      case (op)
         4'h0: begin e.r = x + y; e.c = int'(x) + int'(y) > 255; e.o = ss > 127 || ss < -128; end
         4'h1: begin e.r = x - y; e.c = ge; e.o = subov; end
         4'h3: e.r = x & y;
         4'h4: e.r = x | y;
         4'h5: e.r = x ^ y;
         4'h6: begin e.r = {7'd0, sx < sy}; e.c = ge; e.o = subov; end
         4'h7: begin e.r = {7'd0, x == y}; e.c = ge; e.o = subov; end
         4'h8: begin e.r = {7'd0, x < y}; e.c = ge; e.o = subov; end
         4'h9: e.r = x << sh;
         4'hA: e.r = x >> sh;
         4'hB: e.r = $signed(x) >>> sh;
`ifdef ALU_SEQ_MUL_EN
         4'hC: begin e.r = p[7:0]; e.o = p[15:8] != 0; end
`endif
         default: e.i = 1'b1;
      endcase
      e.z = e.r == 0;
      return e;
   endfunction

   function automatic int exp_lat(input logic [3:0] op, input logic [7:0] y);
      if (op inside {4'h9, 4'hA, 4'hB}) return 1 + int'(y[2:0]);
`ifdef ALU_SEQ_MUL_EN
      if (op == 4'hC) return 9;
`endif
      return 1;
   endfunction

   task automatic send(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
      alu_op = op; a = x; b = y; in_valid = 1;
      for (int t = 0; t < 40; t++) begin
         if (in_ready) begin
            sb.push_back(model(op, x, y));
            @(posedge clk); #1;
            acc_cyc = cyc;
            in_valid = 0; alu_op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
            return;
         end
         @(posedge clk); #1;
      end
      in_valid = 0;
      chk("send_timeout", 0, 1);
   endtask

   task automatic wait_out(input string tag, input int lat_exp, input logic busy);
      int lat = 0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (out_valid) break;
         if (busy) chk({tag, "_busy_in_ready"}, in_ready, 0);
      end
      chk({tag, "_latency"}, lat, lat_exp);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("drain_empty", sb.size(), 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) chk("unexpected_result", 1, 0);
         else begin
            e = sb.pop_front();
            chk("alu_f", alu_f, e.r);
            chk("zero_f", zero_f, e.z);
            chk("over_f", over_f, e.o);
            chk("cout_f", cout_f, e.c);
            chk("illegal_f", illegal_f, e.i);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [7:0] hf;
      logic [3:0] hflags;
      int t0;
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_alu_f", alu_f, 0);
      chk("rst_zero_f", zero_f, 0);
      chk("rst_illegal_f", illegal_f, 0);
      chk("rst_in_ready", in_ready, 1);
      @(negedge clk) rst = 0;
      @(posedge clk); #1;
      send(4'h0, 8'h7F, 8'h01);
      wait_out("add", 1, 0);
      chk("add_f", alu_f, 8'h80);
      chk("add_over", over_f, 1);
      send(4'h1, 8'h05, 8'h05);
      t0 = acc_cyc;
      send(4'h8, 8'h01, 8'hFF);
      chk("b2b_gap", acc_cyc - t0, 1);
      wait_out("b2b", 1, 0);
      chk("b2b_sltu_f", alu_f, 8'h01);
      foreach (vecs[k]) begin
         send(vecs[k].op, vecs[k].x, vecs[k].y);
         wait_out($sformatf("vec%0d", k), exp_lat(vecs[k].op, vecs[k].y), exp_lat(vecs[k].op, vecs[k].y) > 1);
      end
      send(4'hB, 8'h90, 8'h03);
      wait_out("sra", 4, 1);
      chk("sra_f", alu_f, 8'hF2);
      send(4'hC, 8'h10, 8'h11);
`ifdef ALU_SEQ_MUL_EN
      wait_out("mul", 9, 1);
      chk("mul_f", alu_f, 8'h10);
      chk("mul_over", over_f, 1);
`else
      wait_out("mul", 1, 0);
      chk("mul_illegal", illegal_f, 1);
      chk("mul_f", alu_f, 8'h00);
`endif
      for (int k = 0; k < 40; k++) send(4'($urandom), 8'($urandom), 8'($urandom));
      drain();
      @(posedge clk); #1;
      out_ready = 0;
      send(4'h5, 8'hA5, 8'h0F);
      wait_out("stall", 1, 0);
      hf = alu_f;
      hflags = {zero_f, over_f, cout_f, illegal_f};
      repeat (3) begin
         @(negedge clk);
         chk("stall_valid", out_valid, 1);
         chk("stall_alu_f", alu_f, hf);
         chk("stall_flags", {zero_f, over_f, cout_f, illegal_f}, hflags);
         chk("stall_in_ready", in_ready, 0);
      end
      @(posedge clk); #1;
      out_ready = 1;
      @(negedge clk);
      @(negedge clk);
      chk("stall_idle_valid", out_valid, 0);
      chk("stall_idle_in_ready", in_ready, 1);
`ifdef ALU_SEQ_MUL_EN
      send(4'hC, 8'h33, 8'h44);
`else
      send(4'h9, 8'h01, 8'h07);
`endif
      repeat (4) @(negedge clk);
      chk("mid_busy_in_ready", in_ready, 0);
      rst = 1;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_alu_f", alu_f, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      sb.delete();
      @(negedge clk) rst = 0;
      send(4'h0, 8'h12, 8'h34);
      wait_out("post_rst", 1, 0);
      chk("post_rst_f", alu_f, 8'h46);
      drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
